pwm_duty_sequencer: RTL and testbench

Controller in front of the three-phase centre/edge-aligned PWM generator. It accepts duty-triplet commands over a valid/ready handshake and slew-limits each phase toward its target, one step per PWM period. It sequences enable, soft-start, soft-stop and fault shutdown. Outputs drive the PWM's Duty_0..2 and Enable inputs directly and service its interrupt.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_duty_sequencer_if.sv | 17 +
 rtl/pwm_slew_step.sv | 15 +
 rtl/pwm_duty_sequencer.sv | 79 +++++++
 tb/tb_pwm_duty_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding, default widths and duty type for the PWM sequencer
package pwm_pkg;
  localparam int W_DEF = 32;
  localparam int STEP_DEF = 64;
  typedef logic [W_DEF-1:0] duty_t;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    RUN   = 3'd2,
    STOP  = 3'd3,
    FAULT = 3'd4
  } state_t;
endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// pwm_duty_sequencer_if: command handshake, PWM control and status signals of the sequencer
interface pwm_duty_sequencer_if #(parameter int W = pwm_pkg::W_DEF);
  logic [W-1:0] Period, Cmd_Duty_0, Cmd_Duty_1, Cmd_Duty_2, Duty_0, Duty_1, Duty_2;
  logic Period_Tick, Cmd_Valid, Cmd_Ready, Enable_Req, Fault, Fault_Clear;
  logic Pwm_Enable, Irq_Clear, At_Target;
  logic [2:0] State;
  modport master (
    output Period, Period_Tick, Cmd_Valid, Cmd_Duty_0, Cmd_Duty_1, Cmd_Duty_2,
           Enable_Req, Fault, Fault_Clear,
    input  Cmd_Ready, Duty_0, Duty_1, Duty_2, Pwm_Enable, Irq_Clear, State, At_Target
  );
  modport slave (
    input  Period, Period_Tick, Cmd_Valid, Cmd_Duty_0, Cmd_Duty_1, Cmd_Duty_2,
           Enable_Req, Fault, Fault_Clear,
    output Cmd_Ready, Duty_0, Duty_1, Duty_2, Pwm_Enable, Irq_Clear, State, At_Target
  );
endinterface

// File: rtl/pwm_slew_step.sv
// pwm_slew_step: move cur toward tgt by at most step, without wrapping
module pwm_slew_step
  import pwm_pkg::*;
#(parameter int W = W_DEF) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] step,
  output logic [W-1:0] next
);
  logic [W-1:0] up, dn;
  assign up = tgt - cur;
  assign dn = cur - tgt;
  assign next = cur < tgt ? cur + (up < step ? up : step) :
                cur > tgt ? cur - (dn < step ? dn : step) : cur;
endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: command handshake, per-period slew limiting and run/stop/fault sequencing
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int STEP = STEP_DEF
) (
  input logic Clk,
  input logic Reset,
  pwm_duty_sequencer_if.slave bus
);
  state_t state, state_n;
  logic [W-1:0] duty [3], tgt [3], pbuf [3], cmd [3], eff [3], nxt [3];
  logic [2:0] reach, same, at, zero;
  logic pending, irq, hs, active;
  assign active = state == RAMP || state == RUN || state == STOP;
  assign hs = bus.Cmd_Valid && bus.Cmd_Ready;
  assign cmd[0] = bus.Cmd_Duty_0;
  assign cmd[1] = bus.Cmd_Duty_1;
  assign cmd[2] = bus.Cmd_Duty_2;
  for (genvar i = 0; i < 3; i++) begin : g_ph
    logic [W-1:0] t, a;
    // a pending command becomes the target at this tick, so the slew already aims at it
    assign t = pending ? pbuf[i] : tgt[i];
    assign eff[i] = state == STOP ? '0 : (t < bus.Period ? t : bus.Period);
    assign a = state == STOP ? '0 : (tgt[i] < bus.Period ? tgt[i] : bus.Period);
    assign reach[i] = nxt[i] == eff[i];
    assign same[i] = duty[i] == eff[i];
    assign at[i] = duty[i] == a;
    assign zero[i] = duty[i] == '0;
    pwm_slew_step #(.W(W)) u_slew (.cur(duty[i]), .tgt(eff[i]), .step(W'(STEP)), .next(nxt[i]));
  end
  assign bus.Cmd_Ready = !pending && state != FAULT && !Reset;
  assign bus.Duty_0 = duty[0];
  assign bus.Duty_1 = duty[1];
  assign bus.Duty_2 = duty[2];
  assign bus.Pwm_Enable = active;
  assign bus.Irq_Clear = irq;
  assign bus.State = state;
  assign bus.At_Target = &at;
  // next-state: fault overrides everything, ramp/run decisions are taken on ticks
  always_comb begin
    state_n = state;
    if (bus.Fault) state_n = FAULT;
    else
      case (state)
        IDLE:    state_n = bus.Enable_Req ? RAMP : IDLE;
        RAMP:    state_n = !bus.Enable_Req ? STOP : (bus.Period_Tick && &reach) ? RUN : RAMP;
        RUN:     state_n = !bus.Enable_Req ? STOP : (bus.Period_Tick && !(&same)) ? RAMP : RUN;
        STOP:    state_n = bus.Enable_Req ? RAMP : &zero ? IDLE : STOP;
        FAULT:   state_n = bus.Fault_Clear ? IDLE : FAULT;
        default: state_n = IDLE;
      endcase
  end
  // state register and interrupt-clear pulse one cycle after each tick
  always_ff @(posedge Clk) begin
    state <= Reset ? IDLE : state_n;
    irq <= !Reset && bus.Period_Tick;
  end
  // command buffer, targets and duties; fault wipes them like reset
  always_ff @(posedge Clk) begin
    if (Reset || bus.Fault) begin
      duty <= '{default: '0};
      tgt <= '{default: '0};
      pbuf <= '{default: '0};
      pending <= 1'b0;
    end else begin
      if (bus.Period_Tick && pending) begin
        tgt <= pbuf;
        pending <= 1'b0;
      end
      if (hs) begin
        pbuf <= cmd;
        pending <= 1'b1;
      end
      if (bus.Period_Tick && active) duty <= nxt;
    end
  end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer: directed tables plus randomized run against a behavioural model
module tb_pwm_duty_sequencer;
  import pwm_pkg::*;
  localparam int STEP = STEP_DEF;
  typedef struct packed {
    logic [31:0] d0, d1, d2;
    logic [2:0] st;
    logic en;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int m_state = 0;
  duty_t m_duty [3] = '{0, 0, 0};
  duty_t m_tgt [3] = '{0, 0, 0};
  duty_t m_buf [3] = '{0, 0, 0};
  bit m_pend = 0;
  bit m_irq = 0;
  vec_t up_tab [5];
  vec_t dn_tab [6];
  pwm_duty_sequencer_if bus ();
  pwm_duty_sequencer dut (.Clk(clk), .Reset(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic vec_t mk(int d0, int d1, int d2, int st, int en);
    mk.d0 = d0;
    mk.d1 = d1;
    mk.d2 = d2;
    mk.st = 3'(st);
    mk.en = 1'(en);
  endfunction

  function automatic bit m_ready();
    return !m_pend && m_state != 4 && !rst;
  endfunction

  function automatic bit m_at();
    for (int i = 0; i < 3; i++) begin
      duty_t e = m_state == 3 ? '0 : (m_tgt[i] < bus.Period ? m_tgt[i] : bus.Period);
      if (m_duty[i] != e) return 0;
    end
    return 1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("m.duty0", bus.Duty_0, m_duty[0]);
    chk("m.duty1", bus.Duty_1, m_duty[1]);
    chk("m.duty2", bus.Duty_2, m_duty[2]);
    chk("m.state", 32'(bus.State), 32'(m_state));
    chk("m.pwm_enable", 32'(bus.Pwm_Enable), 32'(m_state inside {1, 2, 3}));
    chk("m.irq_clear", 32'(bus.Irq_Clear), 32'(m_irq));
    chk("m.cmd_ready", 32'(bus.Cmd_Ready), 32'(m_ready()));
    chk("m.at_target", 32'(bus.At_Target), 32'(m_at()));
  endtask

  task automatic chk_vec(string nm, vec_t v);
    chk({nm, ".d0"}, bus.Duty_0, v.d0);
    chk({nm, ".d1"}, bus.Duty_1, v.d1);
    chk({nm, ".d2"}, bus.Duty_2, v.d2);
    chk({nm, ".state"}, 32'(bus.State), 32'(v.st));
    chk({nm, ".pwm_enable"}, 32'(bus.Pwm_Enable), 32'(v.en));
  endtask

  // one clock: predict from the rules, advance, compare everything
  task automatic step();
    int ns = m_state;
    bit np = m_pend;
    bit ni = !rst && bus.Period_Tick;
    bit tick = bus.Period_Tick;
    bit en = bus.Enable_Req;
    bit rdy = m_ready();
    bit reach = 1, same = 1, zero = 1;
    longint per = 64'(bus.Period);
    duty_t nd [3], nt [3], nb [3], cmd [3];
    nd = m_duty;
    nt = m_tgt;
    nb = m_buf;
    cmd[0] = bus.Cmd_Duty_0;
    cmd[1] = bus.Cmd_Duty_1;
    cmd[2] = bus.Cmd_Duty_2;
    if (rst || bus.Fault) begin
      ns = rst ? 0 : 4;
      np = 0;
      for (int i = 0; i < 3; i++) begin
        nd[i] = 0;
        nt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        longint t = 64'(m_pend ? m_buf[i] : m_tgt[i]);
        longint e = m_state == 3 ? 0 : (t < per ? t : per);
        longint d = e - 64'(m_duty[i]);
        longint mv;
        if (d > STEP) d = STEP;
        if (d < -STEP) d = -STEP;
        mv = 64'(m_duty[i]) + d;
        if (tick && m_state inside {1, 2, 3}) nd[i] = 32'(mv);
        reach &= (mv == e);
        same &= (64'(m_duty[i]) == e);
        zero &= (m_duty[i] == 0);
      end
      if (tick && m_pend) begin
        nt = m_buf;
        np = 0;
      end
      if (bus.Cmd_Valid && rdy) begin
        nb = cmd;
        np = 1;
      end
      if (m_state == 0 && en) ns = 1;
      if (m_state == 1) ns = !en ? 3 : (tick && reach) ? 2 : 1;
      if (m_state == 2) ns = !en ? 3 : (tick && !same) ? 1 : 2;
      if (m_state == 3) ns = en ? 1 : zero ? 0 : 3;
      if (m_state == 4 && bus.Fault_Clear) ns = 0;
    end
    @(posedge clk);
    #1;
    m_state = ns;
    m_duty = nd;
    m_tgt = nt;
    m_buf = nb;
    m_pend = np;
    m_irq = ni;
    cmp_model();
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic tick();
    bus.Period_Tick = 1;
    step();
    bus.Period_Tick = 0;
  endtask

  task automatic send(int a, int b, int c);
    bus.Cmd_Valid = 1;
    bus.Cmd_Duty_0 = a;
    bus.Cmd_Duty_1 = b;
    bus.Cmd_Duty_2 = c;
    step();
    bus.Cmd_Valid = 0;
  endtask

  function automatic duty_t rnd_duty();
    return $urandom_range(0, 9) == 0 ? $urandom : $urandom_range(0, 1300);
  endfunction

  initial begin
    up_tab[0] = mk(64, 64, 64, 1, 1);
    up_tab[1] = mk(128, 128, 128, 1, 1);
    up_tab[2] = mk(192, 192, 192, 1, 1);
    up_tab[3] = mk(256, 256, 256, 1, 1);
    up_tab[4] = mk(300, 300, 300, 2, 1);
    dn_tab[0] = mk(236, 136, 36, 3, 1);
    dn_tab[1] = mk(172, 72, 0, 3, 1);
    dn_tab[2] = mk(108, 8, 0, 3, 1);
    dn_tab[3] = mk(44, 0, 0, 3, 1);
    dn_tab[4] = mk(0, 0, 0, 3, 1);
    dn_tab[5] = mk(0, 0, 0, 0, 0);
    bus.Period = 1000;
    bus.Period_Tick = 0;
    bus.Cmd_Valid = 0;
    bus.Cmd_Duty_0 = 0;
    bus.Cmd_Duty_1 = 0;
    bus.Cmd_Duty_2 = 0;
    bus.Enable_Req = 0;
    bus.Fault = 0;
    bus.Fault_Clear = 0;
    idle(2);
    chk_vec("reset", mk(0, 0, 0, 0, 0));
    chk("reset.at_target", 32'(bus.At_Target), 1);
    chk("reset.cmd_ready", 32'(bus.Cmd_Ready), 0);
    rst = 0;
    step();
    chk("after_reset.cmd_ready", 32'(bus.Cmd_Ready), 1);
    // soft-start
    bus.Enable_Req = 1;
    step();
    send(300, 300, 300);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_vec("soft_start", up_tab[i]);
      chk("soft_start.irq", 32'(bus.Irq_Clear), 1);
      idle(2);
      chk("soft_start.irq_low", 32'(bus.Irq_Clear), 0);
    end
    chk("soft_start.at_target", 32'(bus.At_Target), 1);
    // clamp to Period
    send(1500, 500, 0);
    repeat (12) begin
      tick();
      idle(1);
    end
    chk_vec("clamp", mk(1000, 500, 0, 2, 1));
    // handshake stall and coincident tick
    bus.Cmd_Valid = 1;
    bus.Cmd_Duty_0 = 1000;
    bus.Cmd_Duty_1 = 500;
    bus.Cmd_Duty_2 = 0;
    step();
    chk("hs.first_taken", 32'(bus.Cmd_Ready), 0);
    bus.Cmd_Duty_0 = 200;
    bus.Cmd_Duty_1 = 200;
    bus.Cmd_Duty_2 = 200;
    idle(2);
    chk("hs.stall", 32'(bus.Cmd_Ready), 0);
    tick();
    chk("hs.ready_after_tick", 32'(bus.Cmd_Ready), 1);
    chk("hs.still_run", 32'(bus.State), 2);
    step();
    chk("hs.second_taken", 32'(bus.Cmd_Ready), 0);
    bus.Cmd_Valid = 0;
    tick();
    chk_vec("hs.apply", mk(936, 436, 64, 1, 1));
    bus.Cmd_Valid = 1;
    bus.Cmd_Duty_0 = 100;
    bus.Cmd_Duty_1 = 100;
    bus.Cmd_Duty_2 = 100;
    bus.Period_Tick = 1;
    step();
    bus.Period_Tick = 0;
    bus.Cmd_Valid = 0;
    chk_vec("hs.coincident", mk(872, 372, 128, 1, 1));
    chk("hs.coincident_pending", 32'(bus.Cmd_Ready), 0);
    idle(1);
    tick();
    chk_vec("hs.deferred", mk(808, 308, 100, 1, 1));
    // soft-stop
    idle(1);
    send(300, 200, 100);
    repeat (20) begin
      tick();
      idle(1);
    end
    chk_vec("run_pos", mk(300, 200, 100, 2, 1));
    bus.Enable_Req = 0;
    step();
    chk("stop.state", 32'(bus.State), 3);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      tick();
      chk_vec("soft_stop", dn_tab[i]);
    end
    step();
    chk_vec("soft_stop.idle", dn_tab[5]);
    // fault mid-ramp
    bus.Enable_Req = 1;
    step();
    send(600, 600, 600);
    tick();
    idle(1);
    tick();
    chk("fault.pre_duty", bus.Duty_0, 128);
    bus.Fault = 1;
    step();
    chk_vec("fault.entry", mk(0, 0, 0, 4, 0));
    chk("fault.cmd_ready", 32'(bus.Cmd_Ready), 0);
    bus.Fault_Clear = 1;
    step();
    bus.Fault_Clear = 0;
    chk("fault.clear_ignored", 32'(bus.State), 4);
    bus.Fault = 0;
    step();
    chk("fault.hold", 32'(bus.State), 4);
    bus.Fault_Clear = 1;
    step();
    bus.Fault_Clear = 0;
    chk("fault.cleared", 32'(bus.State), 0);
    // reset mid-ramp
    step();
    send(500, 500, 500);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      tick();
    end
    chk("rst_mid.pre_duty", bus.Duty_0, 192);
    rst = 1;
    step();
    chk_vec("rst_mid", mk(0, 0, 0, 0, 0));
    chk("rst_mid.at_target", 32'(bus.At_Target), 1);
    chk("rst_mid.irq", 32'(bus.Irq_Clear), 0);
    rst = 0;
    idle(3);
    chk("rst_mid.irq_quiet", 32'(bus.Irq_Clear), 0);
    tick();
    chk("rst_mid.irq_pulse", 32'(bus.Irq_Clear), 1);
    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      bus.Period_Tick = $urandom_range(0, 3) == 0;
      bus.Cmd_Valid = $urandom_range(0, 1) == 1;
      bus.Cmd_Duty_0 = rnd_duty();
      bus.Cmd_Duty_1 = rnd_duty();
      bus.Cmd_Duty_2 = rnd_duty();
      if ($urandom_range(0, 39) == 0) bus.Enable_Req = !bus.Enable_Req;
      bus.Fault = $urandom_range(0, 79) == 0;
      bus.Fault_Clear = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 99) == 0) bus.Period = $urandom_range(200, 1200);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
